muldiv_seq: RTL
===============

# muldiv_seq

Multi-cycle unsigned multiply/divide sequencer for the single-cycle MIPS core. It implements MULTU and DIVU by iterating the shared 32-bit combinational `alu` one step per clock. It drives the ALU's `a`, `b` and `op` inputs and consumes its `result`. The 64-bit result lands in HI/LO registers read by MFHI/MFLO.

## Interface

Parameters:
- `WIDTH`, default 32. Operand width. Only 32 is supported; the iteration counter is log2(WIDTH) = 5 bits.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  request. Accepted only on an edge where `busy`=0.
- `is_div`  in  1  0 = multiply (`src_a` × `src_b`), 1 = divide (`src_a` ÷ `src_b`)
- `src_a`  in  32  multiplicand or dividend. Sampled on the accept edge.
- `src_b`  in  32  multiplier or divisor. Sampled on the accept edge.
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  high for exactly one cycle (DONE state)
- `hi`  out  32  product[63:32] or remainder
- `lo`  out  32  product[31:0] or quotient
- `div_by_zero`  out  1  set on accept of a divide with `src_b`=0. Cleared on accept of any other operation.
- `alu_a`  out  32  to `alu.a`
- `alu_b`  out  32  to `alu.b`
- `alu_op`  out  4  to `alu.op`. Uses 4'b0010 (ADD) or 4'b0110 (SUB).
- `alu_result`  in  32  from `alu.result`. Combinational, same cycle.

## Operation

- States:
  - IDLE → MUL or DIV on accept.
  - MUL or DIV → DONE after iteration 31 (5-bit counter reaches 31).
  - DONE → IDLE unconditionally.
- On accept:
  - Capture `src_a` into the M register (multiply) or `src_b` into the D register (divide).
  - Set `hi`=0 and `lo`=`src_b` (multiply) or `lo`=`src_a` (divide).
  - Counter=0.
- MUL step, performed each cycle:
  - Drive `alu_a`=`hi`, `alu_b`= `lo[0]` ? M : 0, `alu_op`=0010.
  - Compute carry = (`alu_result` < `hi`), unsigned compare.
  - Update `hi` ← {carry, `alu_result`[31:1]} and `lo` ← {`alu_result`[0], `lo`[31:1]}.
- DIV step (restoring division), performed each cycle:
  - Form R' = {`hi`[30:0], `lo`[31]} and top = `hi`[31].
  - Drive `alu_a`=R', `alu_b`=D, `alu_op`=0110.
  - Compute ge = top | (R' ≥ D), unsigned compare.
  - Update `hi` ← ge ? `alu_result` : R' and `lo` ← {`lo`[30:0], ge}.
- IDLE and DONE drive `alu_a`=0, `alu_b`=0, `alu_op`=0010.
- Divide by zero, without the fast path: falls out of the algorithm as `lo`=0xFFFFFFFF, `hi`=dividend.
- `start` while busy (including DONE) is ignored. No queuing.
- `hi`/`lo` show intermediate values while in MUL or DIV. They are architecturally valid in DONE and hold through IDLE until the next accept.
- Reset values: state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0, counter=0.
- Reset mid-operation aborts immediately: IDLE and reset values on the next edge, partial result discarded.

## Timing

- Edge 0 accepts `start`. Edges 1..32 perform iterations 0..31.
- DONE spans edge 32 to edge 33: `done`=1 and results are valid.
- IDLE from edge 33. `busy`=1 from edge 0 to edge 33.
- Total latency from accept to `done`: 32 cycles. Minimum start-to-start spacing: 34 edges.
- `div_by_zero` is valid from edge 0 onward.
- ALU path is combinational within one cycle: `hi`/`lo` regs → `alu_a`/`alu_b` → `alu` → `alu_result` → compare → `hi`/`lo` regs.

## Configuration

- `MULDIV_DIV0_FAST_EN`
  - Defined: a divide accepted with `src_b`=0 goes IDLE → DONE directly, with `hi`=`src_a`, `lo`=0xFFFFFFFF and `div_by_zero`=1. `done` is asserted in the cycle after the accept edge (latency 1). The ALU is not used.
  - Undefined: divide by zero runs the full 32 iterations and produces the identical `hi`/`lo`/`div_by_zero` values at the normal latency.

## Test plan

- Reset, then idle: `hi`=`lo`=0, `busy`=0, `done`=0, `div_by_zero`=0, `alu_op`=0010, `alu_a`=`alu_b`=0.
- MUL 6×2 → `lo`=12, `hi`=0, `done` exactly 32 cycles after the accept edge. MUL 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV 6÷2 → `lo`=3, `hi`=0. DIV 7÷2 → `lo`=3, `hi`=1. DIV 0xFFFFFFFF÷0x10 → `lo`=0x0FFFFFFF, `hi`=0xF. Check `alu_op`=0110 throughout DIV.
- DIV 6÷0 → `div_by_zero`=1, `lo`=0xFFFFFFFF, `hi`=6. Latency 32 without the macro, 1 with `MULDIV_DIV0_FAST_EN`. A following MUL 3×3 → `div_by_zero`=0, `lo`=9.
- `start` pulsed at iteration 10 and again in DONE → ignored. Result unchanged, and no second `done` without a new accept.
- `rst` asserted at iteration 15 of MUL 5×5 → next edge IDLE, `hi`=`lo`=0, `busy`=0. A subsequent MUL 5×5 → `lo`=25.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle unsigned MULTU/DIVU sequencer driving a shared 32-bit ALU.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_start, i_is_div      request (accepted only when idle), 0 = multiply, 1 = divide
//   i_src_a, i_src_b       multiplicand/dividend, multiplier/divisor (sampled on accept)
//   o_busy, o_done         busy in every non-idle state, done for the single DONE cycle
//   o_hi, o_lo             product[63:32]/remainder, product[31:0]/quotient
//   o_div_by_zero          set on accept of a divide by zero, cleared on any other accept
//   o_alu_a/b/op           operands and opcode to the ALU (0010 = ADD, 0110 = SUB)
//   i_alu_result           combinational ALU result, same cycle
//
// Optional: define MULDIV_DIV0_FAST_EN to finish a divide by zero directly in DONE
// (latency 1, ALU unused) instead of running the 32 iterations.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_div_by_zero,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [3:0]       o_alu_op,
    input  logic [WIDTH-1:0] i_alu_result
);

    localparam int unsigned CntW  = $clog2(WIDTH);
    localparam logic [3:0]  OpAdd = 4'b0010;
    localparam logic [3:0]  OpSub = 4'b0110;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e            r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_hi, w_hi_nxt;
    logic [WIDTH-1:0]  r_lo, w_lo_nxt;
    // Multiplicand in multiply, divisor in divide.
    logic [WIDTH-1:0]  r_opnd, w_opnd_nxt;
    logic [CntW-1:0]   r_cnt, w_cnt_nxt;
    logic              r_dbz, w_dbz_nxt;

    logic              w_last;
    logic              w_carry;
    logic              w_ge;
    logic [WIDTH-1:0]  w_rem_sh;

    assign w_last = (r_cnt == CntW'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_opnd_nxt  = r_opnd;
        w_cnt_nxt   = r_cnt;
        w_dbz_nxt   = r_dbz;
        o_alu_a     = '0;
        o_alu_b     = '0;
        o_alu_op    = OpAdd;
        w_carry     = 1'b0;
        w_ge        = 1'b0;
        w_rem_sh    = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_cnt_nxt = '0;
                    w_hi_nxt  = '0;
                    w_dbz_nxt = i_is_div && (i_src_b == '0);
                    if (i_is_div) begin
                        w_opnd_nxt  = i_src_b;
                        w_lo_nxt    = i_src_a;
                        w_state_nxt = StDiv;
`ifdef MULDIV_DIV0_FAST_EN
                        // Same values the iteration would converge to, without the 32 steps.
                        if (i_src_b == '0) begin
                            w_hi_nxt    = i_src_a;
                            w_lo_nxt    = '1;
                            w_state_nxt = StDone;
                        end
`endif
                    end else begin
                        w_opnd_nxt  = i_src_a;
                        w_lo_nxt    = i_src_b;
                        w_state_nxt = StMul;
                    end
                end
            end
            StMul: begin
                // Shift-add: the add's carry-out is recovered by an unsigned wrap compare.
                o_alu_a   = r_hi;
                o_alu_b   = r_lo[0] ? r_opnd : '0;
                o_alu_op  = OpAdd;
                w_carry   = (i_alu_result < r_hi);
                w_hi_nxt  = {w_carry, i_alu_result[WIDTH-1:1]};
                w_lo_nxt  = {i_alu_result[0], r_lo[WIDTH-1:1]};
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDiv: begin
                // Restoring step; the bit shifted out of hi makes the trial subtract succeed.
                o_alu_a   = w_rem_sh;
                o_alu_b   = r_opnd;
                o_alu_op  = OpSub;
                w_ge      = r_hi[WIDTH-1] | (w_rem_sh >= r_opnd);
                w_hi_nxt  = w_ge ? i_alu_result : w_rem_sh;
                w_lo_nxt  = {r_lo[WIDTH-2:0], w_ge};
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opnd  <= '0;
            r_cnt   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_opnd  <= w_opnd_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dbz   <= w_dbz_nxt;
        end
    end

    assign o_busy        = (r_state != StIdle);
    assign o_done        = (r_state == StDone);
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;
    assign o_div_by_zero = r_dbz;

endmodule
